uart_rx_core: RTL and testbench

Bit-level UART receiver that deserializes an 8N1 serial stream into bytes.
- Sits directly upstream of the word-assembly wrapper and feeds it one-cycle byte strobes plus the received byte.
- The wrapper assembles these bytes into 32-bit words for the program loader.
- The io_rx input arrives already double-flopped by the consumer, so this block contains no synchronizer.

---
 rtl/uart_rx_core.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: mid-bit sampling from one absolute cycle counter per frame,
// registered one-cycle byte/framing-error strobes for the word-assembly wrapper.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       io_rx,
  output logic       io_data_valid,
  output logic [7:0] io_data_packet,
  output logic       framing_error,
  output logic       rx_busy
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT * 10);

  // The counter holds (cycle - 1) at each edge, so targets are one below the sample cycle
  localparam logic [CNT_W-1:0] FIRST_SAMPLE = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_STEP     = CNT_W'(CLKS_PER_BIT);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
      $error("uart_rx_core: CLKS_PER_BIT must be 4 or more");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] w_target_nxt;
  logic [2:0]       r_idx;
  logic [2:0]       w_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             r_ok_pend;
  logic             w_ok_pend_nxt;
  logic             r_err_pend;
  logic             w_err_pend_nxt;
  logic             r_valid;
  logic             r_ferr;
  logic             r_busy;
  logic [7:0]       r_packet;
  logic             w_sample;

  assign w_sample = (r_cnt == r_target);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_target_nxt   = r_target;
    w_idx_nxt      = r_idx;
    w_shift_nxt    = r_shift;
    w_ok_pend_nxt  = 1'b0;
    w_err_pend_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!io_rx) begin
          w_state_nxt  = S_START;
          w_cnt_nxt    = '0;
          w_target_nxt = FIRST_SAMPLE;
        end
      end
      S_START: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_sample) begin
          if (!io_rx) begin
            w_state_nxt  = S_DATA;
            w_idx_nxt    = 3'd0;
            w_target_nxt = r_target + BIT_STEP;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_sample) begin
          w_shift_nxt  = {io_rx, r_shift[7:1]};
          w_target_nxt = r_target + BIT_STEP;
          w_idx_nxt    = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_sample) begin
          if (io_rx) begin
            // Back to IDLE right away so a start bit half a bit later is caught
            w_ok_pend_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
          end else begin
            w_err_pend_nxt = 1'b1;
            w_state_nxt    = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (io_rx) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Frame datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_target   <= '0;
      r_idx      <= 3'd0;
      r_shift    <= 8'h00;
      r_ok_pend  <= 1'b0;
      r_err_pend <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_target   <= w_target_nxt;
      r_idx      <= w_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_ok_pend  <= w_ok_pend_nxt;
      r_err_pend <= w_err_pend_nxt;
    end
  end

  // Output strobes land one edge after the stop sample; busy tracks the state one edge late
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
      r_busy   <= 1'b0;
      r_packet <= 8'h00;
    end else begin
      r_valid <= r_ok_pend;
      r_ferr  <= r_err_pend;
      r_busy  <= (r_state != S_IDLE);
      if (r_ok_pend) begin
        r_packet <= r_shift;
      end
    end
  end

  assign io_data_valid  = r_valid;
  assign io_data_packet = r_packet;
  assign framing_error  = r_ferr;
  assign rx_busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at CLKS_PER_BIT=16 and 5; pulses and busy
// transitions are logged by edge number and compared to hand-computed cycles.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx16;
  logic       rx5;
  logic       v16, fe16, bz16;
  logic [7:0] pkt16;
  logic       v5, fe5, bz5;
  logic [7:0] pkt5;

  always #5 clk = ~clk;

  uart_rx_core #(.CLKS_PER_BIT(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .io_rx(rx16),
    .io_data_valid(v16), .io_data_packet(pkt16),
    .framing_error(fe16), .rx_busy(bz16)
  );

  uart_rx_core #(.CLKS_PER_BIT(5)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .io_rx(rx5),
    .io_data_valid(v5), .io_data_packet(pkt5),
    .framing_error(fe5), .rx_busy(bz5)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  int         v16_cyc[$];
  logic [7:0] v16_dat[$];
  int         fe16_cyc[$];
  int         b16_chg[$];
  int         v5_cyc[$];
  logic [7:0] v5_dat[$];
  int         fe5_cyc[$];
  int         b5_chg[$];

  logic       v16_q = 1'b0, fe16_q = 1'b0, bz16_q = 1'b0;
  logic       v5_q = 1'b0, fe5_q = 1'b0, bz5_q = 1'b0;
  logic [7:0] pkt16_q = 8'h00, pkt5_q = 8'h00;

  // Log pulses/busy edges by edge number; count protocol violations
  always @(negedge clk) begin
    if (v16) begin v16_cyc.push_back(cyc); v16_dat.push_back(pkt16); end
    if (fe16) fe16_cyc.push_back(cyc);
    if (bz16 !== bz16_q) b16_chg.push_back(cyc);
    if (v5) begin v5_cyc.push_back(cyc); v5_dat.push_back(pkt5); end
    if (fe5) fe5_cyc.push_back(cyc);
    if (bz5 !== bz5_q) b5_chg.push_back(cyc);
    if ((v16 && fe16) || (v16 && v16_q) || (fe16 && fe16_q)) viol++;
    if ((v5 && fe5) || (v5 && v5_q) || (fe5 && fe5_q)) viol++;
    if (reset_n && !v16 && (pkt16 !== pkt16_q)) viol++;
    if (reset_n && !v5 && (pkt5 !== pkt5_q)) viol++;
    v16_q = v16; fe16_q = fe16; bz16_q = bz16; pkt16_q = pkt16;
    v5_q = v5; fe5_q = fe5; bz5_q = bz5; pkt5_q = pkt5;
  end

  task automatic clear_logs();
    v16_cyc.delete(); v16_dat.delete(); fe16_cyc.delete(); b16_chg.delete();
    v5_cyc.delete(); v5_dat.delete(); fe5_cyc.delete(); b5_chg.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel5, input logic v);
    if (sel5) rx5 = v;
    else      rx16 = v;
  endtask

  // Called #1 after an edge; s is the edge number that first sees the start bit
  task automatic send_frame(input bit sel5, input logic [7:0] b, input logic stop, output int s);
    int cpb;
    cpb = sel5 ? 5 : 16;
    s = cyc + 1;
    drive(sel5, 1'b0);
    idle(cpb);
    for (int i = 0; i < 8; i++) begin
      drive(sel5, b[i]);
      idle(cpb);
    end
    drive(sel5, stop);
    idle(cpb);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(3);
    checks++;
    if ({v16, fe16, bz16, pkt16} !== 11'h0) begin
      errors++;
      $display("FAIL reset_dut16 got v=%b fe=%b busy=%b pkt=%h expected all 0", v16, fe16, bz16, pkt16);
    end
    checks++;
    if ({v5, fe5, bz5, pkt5} !== 11'h0) begin
      errors++;
      $display("FAIL reset_dut5 got v=%b fe=%b busy=%b pkt=%h expected all 0", v5, fe5, bz5, pkt5);
    end
    reset_n = 1'b1;
    idle(5);
    checks++;
    if (bz16 !== 1'b0 || v16 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b v=%b expected 0 0", bz16, v16);
    end
    clear_logs();
  endtask

  task automatic test_single_byte();
    int s;
    clear_logs();
    send_frame(0, 8'hA5, 1'b1, s);
    idle(20);
    checks++;
    if (v16_cyc.size() !== 1) begin
      errors++; $display("FAIL a5_count got %0d expected 1", v16_cyc.size());
    end else begin
      checks++;
      if (v16_cyc[0] !== s + 153) begin
        errors++; $display("FAIL a5_latency got %0d expected %0d", v16_cyc[0] - s, 153);
      end
      checks++;
      if (v16_dat[0] !== 8'hA5) begin
        errors++; $display("FAIL a5_data got %h expected a5", v16_dat[0]);
      end
    end
    checks++;
    if (fe16_cyc.size() !== 0) begin
      errors++; $display("FAIL a5_ferr got %0d pulses expected 0", fe16_cyc.size());
    end
    checks++;
    if (b16_chg.size() !== 2 || b16_chg[0] !== s + 1 || b16_chg[1] !== s + 153) begin
      errors++; $display("FAIL a5_busy got %0d edges expected rise +1 fall +153", b16_chg.size());
    end
    checks++;
    if (pkt16 !== 8'hA5) begin
      errors++; $display("FAIL a5_hold got %h expected a5", pkt16);
    end
  endtask

  task automatic test_glitch();
    int s;
    clear_logs();
    s = cyc + 1;
    rx16 = 1'b0;
    idle(4);
    rx16 = 1'b1;
    idle(300);
    checks++;
    if (v16_cyc.size() !== 0 || fe16_cyc.size() !== 0) begin
      errors++; $display("FAIL glitch_pulse got v=%0d fe=%0d expected 0 0", v16_cyc.size(), fe16_cyc.size());
    end
    checks++;
    if (b16_chg.size() !== 2 || b16_chg[0] !== s + 1 || b16_chg[1] !== s + 9) begin
      errors++; $display("FAIL glitch_busy got %0d edges expected rise +1 fall +9", b16_chg.size());
    end
  endtask

  task automatic test_framing_error();
    int s1, s2, s3;
    int exp_b[6];
    clear_logs();
    send_frame(0, 8'h3C, 1'b1, s1);
    send_frame(0, 8'h5A, 1'b0, s2);
    idle(40);
    rx16 = 1'b1;
    idle(30);
    checks++;
    if (pkt16 !== 8'h3C) begin
      errors++; $display("FAIL ferr_pkt_hold got %h expected 3c", pkt16);
    end
    send_frame(0, 8'h7E, 1'b1, s3);
    idle(20);
    checks++;
    if (fe16_cyc.size() !== 1 || fe16_cyc[0] !== s2 + 153) begin
      errors++; $display("FAIL ferr_pulse got %0d pulses expected 1 at +153", fe16_cyc.size());
    end
    checks++;
    if (v16_cyc.size() !== 2) begin
      errors++; $display("FAIL ferr_valid_count got %0d expected 2", v16_cyc.size());
    end else begin
      checks++;
      if (v16_cyc[0] !== s1 + 153 || v16_dat[0] !== 8'h3C) begin
        errors++; $display("FAIL ferr_first got %h at +%0d expected 3c at +153", v16_dat[0], v16_cyc[0] - s1);
      end
      checks++;
      if (v16_cyc[1] !== s3 + 153 || v16_dat[1] !== 8'h7E) begin
        errors++; $display("FAIL ferr_after got %h at +%0d expected 7e at +153", v16_dat[1], v16_cyc[1] - s3);
      end
    end
    exp_b = '{s1 + 1, s1 + 153, s2 + 1, s2 + 201, s3 + 1, s3 + 153};
    checks++;
    if (b16_chg.size() !== 6) begin
      errors++; $display("FAIL ferr_busy_count got %0d expected 6", b16_chg.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (b16_chg[i] !== exp_b[i]) begin
          errors++; $display("FAIL ferr_busy_edge%0d got %0d expected %0d", i, b16_chg[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int s0, s1, s2, s3;
    logic [7:0] exp_d[4];
    exp_d = '{8'h11, 8'h11, 8'h00, 8'h13};
    clear_logs();
    send_frame(0, exp_d[0], 1'b1, s0);
    send_frame(0, exp_d[1], 1'b1, s1);
    send_frame(0, exp_d[2], 1'b1, s2);
    send_frame(0, exp_d[3], 1'b1, s3);
    idle(20);
    checks++;
    if (v16_cyc.size() !== 4) begin
      errors++; $display("FAIL b2b_count got %0d expected 4", v16_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (v16_cyc[i] !== s0 + 153 + 160 * i || v16_dat[i] !== exp_d[i]) begin
          errors++;
          $display("FAIL b2b_frame%0d got %h at +%0d expected %h at +%0d",
                   i, v16_dat[i], v16_cyc[i] - s0, exp_d[i], 153 + 160 * i);
        end
      end
    end
    checks++;
    if (fe16_cyc.size() !== 0) begin
      errors++; $display("FAIL b2b_ferr got %0d expected 0", fe16_cyc.size());
    end
  endtask

  task automatic test_mid_frame_reset();
    int s;
    clear_logs();
    rx16 = 1'b0;
    idle(16);
    for (int i = 0; i < 4; i++) begin
      rx16 = 1'b1;
      idle(16);
    end
    rx16 = 1'b1;
    idle(8);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({v16, fe16, bz16, pkt16} !== 11'h0) begin
      errors++;
      $display("FAIL midrst_outputs got v=%b fe=%b busy=%b pkt=%h expected all 0", v16, fe16, bz16, pkt16);
    end
    idle(3);
    reset_n = 1'b1;
    idle(200);
    checks++;
    if (v16_cyc.size() !== 0 || fe16_cyc.size() !== 0) begin
      errors++; $display("FAIL midrst_abort got v=%0d fe=%0d expected 0 0", v16_cyc.size(), fe16_cyc.size());
    end
    send_frame(0, 8'h42, 1'b1, s);
    idle(20);
    checks++;
    if (v16_cyc.size() !== 1 || v16_cyc[0] !== s + 153 || v16_dat[0] !== 8'h42) begin
      errors++; $display("FAIL midrst_next got %0d pulses pkt=%h expected 1 pulse 42 at +153", v16_cyc.size(), pkt16);
    end
  endtask

  task automatic test_odd_divisor();
    int s;
    clear_logs();
    send_frame(1, 8'h80, 1'b1, s);
    idle(20);
    checks++;
    if (v5_cyc.size() !== 1) begin
      errors++; $display("FAIL div5_count got %0d expected 1", v5_cyc.size());
    end else begin
      checks++;
      if (v5_cyc[0] !== s + 48 || v5_dat[0] !== 8'h80) begin
        errors++; $display("FAIL div5_frame got %h at +%0d expected 80 at +48", v5_dat[0], v5_cyc[0] - s);
      end
    end
    checks++;
    if (fe5_cyc.size() !== 0 || b5_chg.size() !== 2 || b5_chg[0] !== s + 1 || b5_chg[1] !== s + 48) begin
      errors++; $display("FAIL div5_busy got fe=%0d edges=%0d expected 0 and rise +1 fall +48",
                         fe5_cyc.size(), b5_chg.size());
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL strobe_invariants got %0d violations expected 0", viol);
    end
  endtask

  initial begin
    rx16    = 1'b1;
    rx5     = 1'b1;
    reset_n = 1'b0;
    #1;
    test_reset();
    test_single_byte();
    test_glitch();
    test_framing_error();
    test_back_to_back();
    test_mid_frame_reset();
    test_odd_divisor();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
